// File: rtl/sad_search_if.sv
// Handshake bundle between the SAD search controller, the SAD datapath and
// the min-SAD register. The controller uses the slave view.
interface sad_search_if;
  logic        start;
  logic        abort;
  logic        sad_start;
  logic [7:0]  sad_row;
  logic [7:0]  sad_column;
  logic        sad_valid;
  logic [31:0] sad_in;
  logic [31:0] cand_sad;
  logic [7:0]  cand_row;
  logic [7:0]  cand_column;
  logic        reg_rst;
  logic [31:0] min_sad_in;
  logic [7:0]  min_row_in;
  logic [7:0]  min_column_in;
  logic        busy;
  logic        done;
  logic [31:0] best_sad;
  logic [7:0]  best_row;
  logic [7:0]  best_column;

  modport slave (
    input  start, abort, sad_valid, sad_in, min_sad_in, min_row_in, min_column_in,
    output sad_start, sad_row, sad_column, cand_sad, cand_row, cand_column,
           reg_rst, busy, done, best_sad, best_row, best_column
  );

  modport master (
    output start, abort, sad_valid, sad_in, min_sad_in, min_row_in, min_column_in,
    input  sad_start, sad_row, sad_column, cand_sad, cand_row, cand_column,
           reg_rst, busy, done, best_sad, best_row, best_column
  );
endinterface

// File: rtl/sad_search_controller.sv
// Full-search motion-estimation sequencer: walks every candidate of the search
// window through the SAD datapath and latches the minimum from the min-SAD register.
module sad_search_controller #(
  parameter int NUM_ROWS = 16,
  parameter int NUM_COLS = 16
) (
  input logic         clk,
  input logic         rst,
  sad_search_if.slave bus
);

  localparam logic [7:0] LAST_ROW = 8'(NUM_ROWS - 1);
  localparam logic [7:0] LAST_COL = 8'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state_reg;
  logic [7:0]  row_reg;
  logic [7:0]  col_reg;
  logic        sad_start_reg;
  logic        reg_rst_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [31:0] best_sad_reg;
  logic [7:0]  best_row_reg;
  logic [7:0]  best_col_reg;

  logic accept;
  logic last_cand;

  // Abort outranks a simultaneous result so the register never sees a partial search.
  assign accept    = (state_reg == S_WAIT) && bus.sad_valid && !bus.abort;
  assign last_cand = (row_reg == LAST_ROW) && (col_reg == LAST_COL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      row_reg       <= 8'd0;
      col_reg       <= 8'd0;
      sad_start_reg <= 1'b0;
      reg_rst_reg   <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      best_sad_reg  <= 32'd32767;
      best_row_reg  <= 8'd0;
      best_col_reg  <= 8'd0;
    end else begin
      sad_start_reg <= 1'b0;
      reg_rst_reg   <= 1'b0;
      done_reg      <= 1'b0;
      if (bus.abort && state_reg != S_IDLE) begin
        state_reg   <= S_IDLE;
        busy_reg    <= 1'b0;
        reg_rst_reg <= 1'b1;
        row_reg     <= 8'd0;
        col_reg     <= 8'd0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (bus.start) begin
              state_reg   <= S_CLEAR;
              busy_reg    <= 1'b1;
              reg_rst_reg <= 1'b1;
              row_reg     <= 8'd0;
              col_reg     <= 8'd0;
            end
          end
          S_CLEAR: begin
            state_reg     <= S_ISSUE;
            sad_start_reg <= 1'b1;
          end
          S_ISSUE: begin
            state_reg <= S_WAIT;
          end
          S_WAIT: begin
            if (accept) begin
              if (last_cand) begin
                state_reg <= S_DRAIN;
              end else begin
                state_reg     <= S_ISSUE;
                sad_start_reg <= 1'b1;
                if (col_reg == LAST_COL) begin
                  col_reg <= 8'd0;
                  row_reg <= row_reg + 8'd1;
                end else begin
                  col_reg <= col_reg + 8'd1;
                end
              end
            end
          end
          S_DRAIN: begin
            // Register output now reflects the final candidate; latch it with Done.
            state_reg    <= S_DONE;
            done_reg     <= 1'b1;
            best_sad_reg <= bus.min_sad_in;
            best_row_reg <= bus.min_row_in;
            best_col_reg <= bus.min_column_in;
          end
          S_DONE: begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
          default: begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sad_start   = sad_start_reg;
  assign bus.sad_row     = row_reg;
  assign bus.sad_column  = col_reg;
  assign bus.cand_sad    = accept ? bus.sad_in : 32'hFFFF_FFFF;
  assign bus.cand_row    = accept ? row_reg : 8'd0;
  assign bus.cand_column = accept ? col_reg : 8'd0;
  assign bus.reg_rst     = reg_rst_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.best_sad    = best_sad_reg;
  assign bus.best_row    = best_row_reg;
  assign bus.best_column = best_col_reg;

endmodule

// File: tb/tb_sad_search_controller.sv
// Directed bench: table of 2x2 searches plus hand sequences for abort,
// asynchronous reset and the single-candidate window.
module tb_sad_search_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sad_search_if bus0 ();
  sad_search_if bus1 ();

  sad_search_controller #(.NUM_ROWS(2), .NUM_COLS(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sad_search_controller #(.NUM_ROWS(1), .NUM_COLS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Behavioural min-SAD registers (strict-less compare, reset by reg_rst).
  always_ff @(posedge clk) begin
    if (bus0.reg_rst) begin
      bus0.min_sad_in    <= 32'hFFFF_FFFF;
      bus0.min_row_in    <= 8'd0;
      bus0.min_column_in <= 8'd0;
    end else if (bus0.cand_sad < bus0.min_sad_in) begin
      bus0.min_sad_in    <= bus0.cand_sad;
      bus0.min_row_in    <= bus0.cand_row;
      bus0.min_column_in <= bus0.cand_column;
    end
  end

  always_ff @(posedge clk) begin
    if (bus1.reg_rst) begin
      bus1.min_sad_in    <= 32'hFFFF_FFFF;
      bus1.min_row_in    <= 8'd0;
      bus1.min_column_in <= 8'd0;
    end else if (bus1.cand_sad < bus1.min_sad_in) begin
      bus1.min_sad_in    <= bus1.cand_sad;
      bus1.min_row_in    <= bus1.cand_row;
      bus1.min_column_in <= bus1.cand_column;
    end
  end

  typedef struct {
    logic [3:0][31:0] sads;
    int               dly;
    logic [31:0]      best;
    logic [7:0]       row;
    logic [7:0]       col;
    int               lat;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_search(input vec_t v, input int idx);
    int cyc;
    int t;
    @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    cyc = 1;
    chk("clear_reg_rst", 32'(bus0.reg_rst), 32'd1);
    chk("clear_busy", 32'(bus0.busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      t = 0;
      do begin
        @(negedge clk);
        cyc++;
        t++;
        bus0.sad_valid = 1'b0;
      end while (!bus0.sad_start && t < 50);
      chk("issue_seen", 32'(bus0.sad_start), 32'd1);
      chk("issue_row", 32'(bus0.sad_row), 32'(k / 2));
      chk("issue_col", 32'(bus0.sad_column), 32'(k % 2));
      for (int j = 1; j <= v.dly; j++) begin
        @(negedge clk);
        cyc++;
        chk("start_single", 32'(bus0.sad_start), 32'd0);
        chk("row_stable", 32'(bus0.sad_row), 32'(k / 2));
        chk("col_stable", 32'(bus0.sad_column), 32'(k % 2));
        if (j < v.dly) begin
          chk("cand_idle", bus0.cand_sad, 32'hFFFF_FFFF);
        end else begin
          bus0.sad_valid = 1'b1;
          bus0.sad_in    = v.sads[k];
          #1;
          chk("cand_sad", bus0.cand_sad, v.sads[k]);
          chk("cand_row", 32'(bus0.cand_row), 32'(k / 2));
          chk("cand_col", 32'(bus0.cand_column), 32'(k % 2));
        end
      end
    end
    t = 0;
    do begin
      @(negedge clk);
      cyc++;
      t++;
      bus0.sad_valid = 1'b0;
    end while (!bus0.done && t < 50);
    chk("done_seen", 32'(bus0.done), 32'd1);
    chk("best_sad", bus0.best_sad, v.best);
    chk("best_row", 32'(bus0.best_row), 32'(v.row));
    chk("best_col", 32'(bus0.best_column), 32'(v.col));
    chk("latency", 32'(cyc), 32'(v.lat));
    @(negedge clk);
    chk("done_one_cycle", 32'(bus0.done), 32'd0);
    chk("idle_busy", 32'(bus0.busy), 32'd0);
    $display("search %0d: best_sad=%0d row=%0d col=%0d latency=%0d", idx,
             bus0.best_sad, bus0.best_row, bus0.best_column, cyc);
  endtask

  initial begin
    int   cyc;
    int   t;
    logic saw;

    vecs[0] = '{sads: {32'd10, 32'd30, 32'd25, 32'd40}, dly: 1, best: 32'd10, row: 8'd1, col: 8'd1, lat: 11};
    vecs[1] = '{sads: {32'd60, 32'd50, 32'd20, 32'd20}, dly: 1, best: 32'd20, row: 8'd0, col: 8'd0, lat: 11};
    vecs[2] = '{sads: {32'd95, 32'd90, 32'd90, 32'd100}, dly: 5, best: 32'd90, row: 8'd0, col: 8'd1, lat: 27};
    vecs[3] = '{sads: {32'd9, 32'd3, 32'd3, 32'd7}, dly: 2, best: 32'd3, row: 8'd0, col: 8'd1, lat: 15};
    vecs[4] = '{sads: {32'd0, 32'd998, 32'd999, 32'd1000}, dly: 1, best: 32'd0, row: 8'd1, col: 8'd1, lat: 11};

    rst = 1'b1;
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.sad_valid = 1'b0; bus0.sad_in = 32'd0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.sad_valid = 1'b0; bus1.sad_in = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_reg_rst", 32'(bus0.reg_rst), 32'd1);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_done", 32'(bus0.done), 32'd0);
    chk("rst_sad_start", 32'(bus0.sad_start), 32'd0);
    chk("rst_best_sad", bus0.best_sad, 32'd32767);
    chk("rst_best_row", 32'(bus0.best_row), 32'd0);
    chk("rst_cand_sad", bus0.cand_sad, 32'hFFFF_FFFF);
    chk("rst_sad_row", 32'(bus0.sad_row), 32'd0);
    chk("rst_best_sad_1x1", bus1.best_sad, 32'd32767);
    rst = 1'b0;

    foreach (vecs[i]) run_search(vecs[i], i);

    // Abort in WAIT of the second candidate, with a simultaneous result.
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    @(negedge clk);
    @(negedge clk); bus0.sad_valid = 1'b1; bus0.sad_in = 32'd3;
    @(negedge clk); bus0.sad_valid = 1'b0;
    chk("abort_issue2", 32'(bus0.sad_start), 32'd1);
    chk("abort_col2", 32'(bus0.sad_column), 32'd1);
    @(negedge clk); bus0.abort = 1'b1; bus0.sad_valid = 1'b1; bus0.sad_in = 32'd1;
    #1;
    chk("abort_beats_valid", bus0.cand_sad, 32'hFFFF_FFFF);
    @(negedge clk); bus0.abort = 1'b0; bus0.sad_valid = 1'b0;
    chk("abort_busy", 32'(bus0.busy), 32'd0);
    chk("abort_reg_rst", 32'(bus0.reg_rst), 32'd1);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus0.done || bus0.sad_start || bus0.busy) saw = 1'b1;
    end
    chk("abort_quiet", 32'(saw), 32'd0);
    chk("abort_best_kept", bus0.best_sad, 32'd0);
    chk("abort_min_cleared", bus0.min_sad_in, 32'hFFFF_FFFF);
    $display("abort: best_sad=%0d busy=%0d", bus0.best_sad, bus0.busy);
    run_search(vecs[0], 5);

    // Asynchronous reset during WAIT of the last candidate.
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bus0.sad_valid = 1'b0;
      @(negedge clk); bus0.sad_valid = 1'b1; bus0.sad_in = 32'd50;
    end
    @(negedge clk); bus0.sad_valid = 1'b0;
    chk("pre_rst_row", 32'(bus0.sad_row), 32'd1);
    chk("pre_rst_col", 32'(bus0.sad_column), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus0.busy), 32'd0);
    chk("arst_reg_rst", 32'(bus0.reg_rst), 32'd1);
    chk("arst_row", 32'(bus0.sad_row), 32'd0);
    chk("arst_col", 32'(bus0.sad_column), 32'd0);
    chk("arst_best_sad", bus0.best_sad, 32'd32767);
    @(negedge clk); rst = 1'b0; bus0.sad_valid = 1'b1; bus0.sad_in = 32'd1;
    #1;
    chk("stray_cand", bus0.cand_sad, 32'hFFFF_FFFF);
    @(negedge clk); bus0.sad_valid = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus0.done || bus0.sad_start || bus0.busy) saw = 1'b1;
    end
    chk("stray_ignored", 32'(saw), 32'd0);
    chk("stray_best_sad", bus0.best_sad, 32'd32767);
    $display("async reset: busy=%0d best_sad=%0d", bus0.busy, bus0.best_sad);

    // Single-candidate window.
    @(negedge clk); bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
    cyc = 1;
    t = 0;
    do begin
      @(negedge clk);
      cyc++;
      t++;
    end while (!bus1.sad_start && t < 50);
    chk("one_issue", 32'(bus1.sad_start), 32'd1);
    chk("one_row", 32'(bus1.sad_row), 32'd0);
    chk("one_col", 32'(bus1.sad_column), 32'd0);
    @(negedge clk); cyc++; bus1.sad_valid = 1'b1; bus1.sad_in = 32'd7;
    @(negedge clk); cyc++; bus1.sad_valid = 1'b0;
    chk("one_drain_no_issue", 32'(bus1.sad_start), 32'd0);
    chk("one_drain_busy", 32'(bus1.busy), 32'd1);
    @(negedge clk); cyc++;
    chk("one_done", 32'(bus1.done), 32'd1);
    chk("one_best_sad", bus1.best_sad, 32'd7);
    chk("one_latency", 32'(cyc), 32'd5);
    $display("single candidate: best_sad=%0d latency=%0d", bus1.best_sad, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sad_search_controller.md
SAD_SEARCH_CONTROLLER -- requirements
Module: sad_search_controller

Interface
REQ-001 Parameter NUM_ROWS, default 16, number of candidate rows in the search window (1..255).
REQ-002 Parameter NUM_COLS, default 16, number of candidate columns in the search window (1..255).
REQ-003 Clk  in  1  sole clock; all state updates on posedge Clk.
REQ-004 Rst  in  1  reset, asynchronous, active-high.
REQ-005 Start  in  1  request a new full-window search; sampled only in IDLE.
REQ-006 Abort  in  1  terminate the current search, return to IDLE; no Done pulse.
REQ-007 SADStart  out  1  one-cycle pulse ordering the SAD datapath to evaluate (SADRow, SADColumn).
REQ-008 SADRow, SADColumn  out  8 each  candidate position under evaluation.
REQ-009 SADValid  in  1  datapath result strobe for the outstanding candidate.
REQ-010 SADIn  in  32  datapath SAD result, qualified by SADValid.
REQ-011 CandSAD  out  32  candidate value fed to the min-SAD register.
REQ-012 CandRow, CandColumn  out  8 each  candidate position fed to the min-SAD register.
REQ-013 RegRst  out  1  reset for the min-SAD register.
REQ-014 MinSADIn  in  32  current minimum from the min-SAD register.
REQ-015 MinRowIn, MinColumnIn  in  8 each  position of current minimum.
REQ-016 Busy  out  1  high in every state except IDLE.
REQ-017 Done  out  1  one-cycle pulse when results are valid.
REQ-018 BestSAD  out  32; BestRow, BestColumn  out  8 each  latched search result.

Function
REQ-019 FSM states: IDLE, CLEAR, ISSUE, WAIT, DRAIN, DONE.
REQ-020 IDLE -> CLEAR when Start=1; otherwise stay.
REQ-021 CLEAR: RegRst=1 for exactly one cycle; row/col counters load 0; -> ISSUE.
REQ-022 ISSUE: SADStart=1 for exactly one cycle; -> WAIT.
REQ-023 SADRow/SADColumn reflect counters, held stable from ISSUE until SADValid is accepted.
REQ-024 WAIT: stay until SADValid=1; SADValid outside WAIT is ignored.
REQ-025 In the WAIT cycle with SADValid=1: CandSAD=SADIn, CandRow/CandColumn=current counters; all other cycles CandSAD=32'hFFFFFFFF and CandRow/CandColumn=0, so the register cannot update.
REQ-026 Scan order column-major within row: column increments first; at NUM_COLS-1 column wraps to 0 and row increments.
REQ-027 On accepted SADValid: if row=NUM_ROWS-1 and column=NUM_COLS-1 -> DRAIN, else advance counters -> ISSUE.
REQ-028 DRAIN: one idle cycle so the register output reflects the final candidate; -> DONE.
REQ-029 DONE: BestSAD/BestRow/BestColumn <= MinSADIn/MinRowIn/MinColumnIn; Done=1 one cycle; -> IDLE.
REQ-030 Best* outputs hold value until the next DONE or reset; unaffected by Abort.
REQ-031 Total candidates per search = NUM_ROWS*NUM_COLS; latency Start->Done = 2 + sum over candidates of (1 + WAIT cycles) + 1 DRAIN cycle.
REQ-032 Abort=1 in any non-IDLE state -> IDLE next cycle, RegRst=1 in that cycle, takes priority over SADValid and Done; Abort in IDLE ignored.
REQ-033 Start while Busy ignored; Start and Abort together in IDLE: start proceeds.
REQ-034 NUM_ROWS=NUM_COLS=1: single candidate, ISSUE -> WAIT -> DRAIN directly.
REQ-035 Equal SAD values: first candidate in scan order wins (strict-less register compare); controller adds no tie logic.

Reset
REQ-036 Rst=1 asynchronously forces IDLE, counters 0, SADStart/Done/Busy=0, RegRst=1 while Rst held.
REQ-037 Reset values: SADRow/SADColumn=0, CandSAD=32'hFFFFFFFF, CandRow/CandColumn=0, BestSAD=32767, BestRow/BestColumn=0.
REQ-038 Rst mid-search discards progress; no Done pulse; outstanding SADValid after reset ignored.

Verification (NUM_ROWS=2, NUM_COLS=2 unless stated)
REQ-039 Start, SADValid 1 cycle after each SADStart with SADs 40,25,30,10 -> SADStart at (0,0),(0,1),(1,0),(1,1); Done with BestSAD=10, BestRow=1, BestColumn=1; Start->Done=11 cycles.
REQ-040 SADs 20,20,50,60 -> Best=(20,row 0,col 0); tie keeps first.
REQ-041 SADValid delayed 5 cycles per candidate -> SADStart single pulse each, SADRow/SADColumn stable throughout, CandSAD=FFFFFFFF except accept cycles.
REQ-042 Abort in WAIT of second candidate -> IDLE next cycle, RegRst pulse, no Done, Best* unchanged; later Start runs full search normally.
REQ-043 Rst asserted in WAIT asynchronously -> outputs at reset values before next edge; stray SADValid after release ignored.
REQ-044 NUM_ROWS=NUM_COLS=1, SAD 7 -> one SADStart at (0,0), Done with BestSAD=7.
